// File: rtl/alu_control_muldiv.sv
// ALU control decode plus iterative multiply/divide engine with HI/LO registers.
// Decode is combinational. Mul/div takes WIDTH+3 cycles (4 for divide-by-zero), with stall held high while busy.
module alu_control_muldiv #(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 3,
    parameter int EN_DIV  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [5:0]         ALUFunction,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic [3:0]         ALUOperation,
    output logic               stall,
    output logic [WIDTH-1:0]   hilo_data,
    output logic               done,
    output logic               div_by_zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [ALUOP_W-1:0] OP_R   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_LUI = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(4);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     breg, a_raw, hi, lo;
    logic [CW-1:0]        cnt;
    logic                 op_div, neg_q, neg_r, div0;

    logic                 is_rtype, mul_req, div_req, start, signed_op, last;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum, div_part, div_diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_nxt;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    always_comb begin
        ALUOperation = 4'b1111;
        if (ALUOp == OP_R) begin
            case (ALUFunction)
                6'h20:   ALUOperation = 4'b0011;
                6'h22:   ALUOperation = 4'b0100;
                6'h24:   ALUOperation = 4'b0000;
                6'h25:   ALUOperation = 4'b0001;
                6'h27:   ALUOperation = 4'b0010;
                6'h00:   ALUOperation = 4'b0110;
                6'h02:   ALUOperation = 4'b0111;
                6'h10:   ALUOperation = 4'b1000;
                6'h12:   ALUOperation = 4'b1001;
                default: ALUOperation = 4'b1111;
            endcase
        end else begin
            case (ALUOp)
                OP_ADD:  ALUOperation = 4'b0011;
                OP_OR:   ALUOperation = 4'b0001;
                OP_AND:  ALUOperation = 4'b0000;
                OP_LUI:  ALUOperation = 4'b0101;
                OP_SUB:  ALUOperation = 4'b0100;
                default: ALUOperation = 4'b1111;
            endcase
        end
    end

    // A held reset suppresses start so stall cannot assert before the engine is live.
    assign is_rtype  = (ALUOp == OP_R);
    assign mul_req   = is_rtype && (ALUFunction == 6'h18 || ALUFunction == 6'h19);
    assign div_req   = (EN_DIV != 0) && is_rtype && (ALUFunction == 6'h1A || ALUFunction == 6'h1B);
    assign start     = reset && (state == S_IDLE) && (mul_req || div_req);
    assign signed_op = ~ALUFunction[0];
    assign abs_a     = (signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign abs_b     = (signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    assign last      = (cnt == CW'(WIDTH - 1));

    assign hilo_data = !is_rtype             ? '0 :
                       (ALUFunction == 6'h10) ? hi :
                       (ALUFunction == 6'h12) ? lo : '0;

    // Shift-add step; restoring-division step on {remainder, quotient} in the same accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, breg} : '0);
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, breg};
        q_bit    = (div_part >= {1'b0, breg});
        rem_nxt  = q_bit ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (op_div) begin
            if (div0) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                fix_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = div_req ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                stall = 1'b1;
                if (last) state_nxt = S_FIX;
            end
            S_DIV: begin
                stall = 1'b1;
                if (breg == '0 || last) state_nxt = S_FIX;
            end
            S_FIX: begin
                stall     = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign done        = (state == S_DONE);
    assign div_by_zero = done && div0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            breg   <= '0;
            a_raw  <= '0;
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= {{WIDTH{1'b0}}, abs_a};
                        breg   <= abs_b;
                        a_raw  <= operand_a;
                        cnt    <= '0;
                        op_div <= div_req;
                        neg_q  <= signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        neg_r  <= signed_op && operand_a[WIDTH-1];
                        div0   <= 1'b0;
                    end
                end
                S_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                S_DIV: begin
                    if (breg == '0) begin
                        div0 <= 1'b1;
                    end else begin
                        acc <= {rem_nxt, acc[WIDTH-2:0], q_bit};
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_control_muldiv.sv
// Directed bench for alu_control_muldiv: decode sweep, mul/div results and latency, interlock, reset abort.
module tb_alu_control_muldiv;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] opa, opb;
    logic [3:0]  aluoperation;
    logic        stall, done, dz;
    logic [31:0] hilo;

    logic        reset16;
    logic [2:0]  aluop16;
    logic [5:0]  funct16;
    logic [15:0] opa16, opb16;
    logic [3:0]  aluoperation16;
    logic        stall16, done16, dz16;
    logic [15:0] hilo16;

    int total = 0;
    int bad   = 0;

    alu_control_muldiv #(.WIDTH(32), .ALUOP_W(3), .EN_DIV(1)) dut (
        .clk(clk), .reset(reset), .ALUOp(aluop), .ALUFunction(funct),
        .operand_a(opa), .operand_b(opb), .ALUOperation(aluoperation),
        .stall(stall), .hilo_data(hilo), .done(done), .div_by_zero(dz)
    );

    alu_control_muldiv #(.WIDTH(16), .ALUOP_W(3), .EN_DIV(1)) dut16 (
        .clk(clk), .reset(reset16), .ALUOp(aluop16), .ALUFunction(funct16),
        .operand_a(opa16), .operand_b(opb16), .ALUOperation(aluoperation16),
        .stall(stall16), .hilo_data(hilo16), .done(done16), .div_by_zero(dz16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic [2:0] op, input logic [5:0] f, input logic [3:0] e);
        aluop = op;
        funct = f;
        #1;
        chk($sformatf("dec_%0h_%02h", op, f), 64'(aluoperation), 64'(e));
    endtask

    // Entered just after a rising edge; leaves just after the edge following DONE.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int ns, output logic dn, output logic dzo);
        aluop = 3'b111;
        funct = f;
        opa   = a;
        opb   = b;
        ns    = 0;
        #4;
        for (int i = 0; i < 80 && stall; i++) begin
            ns++;
            @(posedge clk);
            #5;
        end
        dn  = done;
        dzo = dz;
        @(posedge clk);
        #1;
        aluop = 3'b000;
        funct = 6'h00;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        aluop = 3'b111;
        funct = 6'h10;
        #4;
        chk({tag, "_hi"}, 64'(hilo), 64'(ehi));
        @(posedge clk);
        #1;
        funct = 6'h12;
        #4;
        chk({tag, "_lo"}, 64'(hilo), 64'(elo));
        @(posedge clk);
        #1;
        aluop = 3'b000;
        funct = 6'h00;
    endtask

    task automatic engine(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int ens, input logic edz,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int   ns;
        logic dn, dzo;
        run_op(f, a, b, ns, dn, dzo);
        chk({tag, "_stall_cycles"}, 64'(ns), 64'(ens));
        chk({tag, "_done"}, 64'(dn), 64'(1));
        chk({tag, "_div0"}, 64'(dzo), 64'(edz));
        read_hilo(tag, ehi, elo);
    endtask

    initial begin
        int   ns;
        logic seen;

        reset   = 1'b0;
        reset16 = 1'b0;
        aluop   = 3'b111;
        funct   = 6'h10;
        opa     = '0;
        opb     = '0;
        aluop16 = 3'b000;
        funct16 = 6'h00;
        opa16   = '0;
        opb16   = '0;
        #1;
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_div0", 64'(dz), 64'(0));
        chk("rst_hi", 64'(hilo), 64'(0));

        // Decode sweep while reset holds the engine idle.
        dec(3'b111, 6'h20, 4'b0011);
        dec(3'b111, 6'h22, 4'b0100);
        dec(3'b111, 6'h24, 4'b0000);
        dec(3'b111, 6'h25, 4'b0001);
        dec(3'b111, 6'h27, 4'b0010);
        dec(3'b111, 6'h00, 4'b0110);
        dec(3'b111, 6'h02, 4'b0111);
        dec(3'b111, 6'h08, 4'b1111);
        dec(3'b111, 6'h10, 4'b1000);
        dec(3'b111, 6'h12, 4'b1001);
        dec(3'b111, 6'h18, 4'b1111);
        dec(3'b111, 6'h19, 4'b1111);
        dec(3'b111, 6'h1A, 4'b1111);
        dec(3'b111, 6'h1B, 4'b1111);
        dec(3'b111, 6'h3F, 4'b1111);
        dec(3'b000, 6'h3F, 4'b0011);
        dec(3'b001, 6'h3F, 4'b0001);
        dec(3'b010, 6'h3F, 4'b0000);
        dec(3'b011, 6'h3F, 4'b0101);
        dec(3'b100, 6'h3F, 4'b0100);
        dec(3'b101, 6'h3F, 4'b1111);
        dec(3'b110, 6'h3F, 4'b1111);

        @(posedge clk);
        #1;
        reset   = 1'b1;
        reset16 = 1'b1;
        aluop   = 3'b000;
        funct   = 6'h00;
        @(posedge clk);
        #1;

        engine("multu", 6'h19, 32'hFFFFFFFF, 32'h2, 34, 1'b0, 32'h00000001, 32'hFFFFFFFE);
        engine("mult", 6'h18, 32'hFFFFFFFD, 32'h7, 34, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        engine("div", 6'h1A, 32'hFFFFFFF9, 32'h2, 34, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        engine("div_min", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 34, 1'b0, 32'h0, 32'h80000000);
        engine("divu", 6'h1B, 32'd100, 32'd7, 34, 1'b0, 32'd2, 32'd14);
        engine("divu0", 6'h1B, 32'h1234, 32'h0, 3, 1'b1, 32'h00001234, 32'hFFFFFFFF);

        // MFLO arrives while a MULT is still iterating.
        aluop = 3'b111;
        funct = 6'h18;
        opa   = 32'd5;
        opb   = 32'd6;
        repeat (5) @(posedge clk);
        #1;
        funct = 6'h12;
        #4;
        chk("mflo_busy_stall", 64'(stall), 64'(1));
        ns = 0;
        for (int i = 0; i < 80 && stall; i++) begin
            ns++;
            @(posedge clk);
            #5;
        end
        chk("mflo_stall_cycles", 64'(ns + 5), 64'(34));
        chk("mflo_done", 64'(done), 64'(1));
        chk("mflo_value", 64'(hilo), 64'(32'h0000001E));
        @(posedge clk);
        #1;
        aluop = 3'b000;
        funct = 6'h00;

        // Reset drops in cycle 10 of a DIV.
        aluop = 3'b111;
        funct = 6'h1A;
        opa   = 32'd100;
        opb   = 32'd3;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy", 64'(stall), 64'(1));
        reset = 1'b0;
        #4;
        chk("abort_stall", 64'(stall), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        aluop = 3'b000;
        funct = 6'h00;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #4;
            if (done || stall) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        read_hilo("abort", 32'h0, 32'h0);

        // 16-bit instance: largest unsigned product.
        aluop16 = 3'b111;
        funct16 = 6'h19;
        opa16   = 16'hFFFF;
        opb16   = 16'hFFFF;
        ns      = 0;
        #4;
        for (int i = 0; i < 40 && stall16; i++) begin
            ns++;
            @(posedge clk);
            #5;
        end
        chk("w16_stall_cycles", 64'(ns), 64'(18));
        chk("w16_done", 64'(done16), 64'(1));
        @(posedge clk);
        #1;
        funct16 = 6'h10;
        #4;
        chk("w16_hi", 64'(hilo16), 64'(16'hFFFE));
        @(posedge clk);
        #1;
        funct16 = 6'h12;
        #4;
        chk("w16_lo", 64'(hilo16), 64'(16'h0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
